// File: rtl/glb_pe_pkg.sv
// Shared types for the global PE loop controller: FSM states, config bundle, legality check.
package glb_pe_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_ROW    = 4;
  localparam int DEF_NUM_COL    = 4;
  localparam int DEF_CNT_W      = 8;

  localparam int K_W   = $clog2(DEF_NUM_ROW + 1);
  localparam int ROW_W = $clog2(DEF_NUM_ROW);
  localparam int COL_W = $clog2(DEF_NUM_COL);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [K_W-1:0]         k;
    logic [DEF_CNT_W-1:0]   w;
    logic [DEF_CNT_W-1:0]   passes;
  } cfg_t;

  // A kernel must fit the array in both dimensions and the row must cover at least one window.
  function automatic logic cfg_legal(input int k, input int w, input int passes,
                                     input int max_row, input int max_col);
    return !(k == 0 || k > max_row || k > max_col || w < k || passes == 0);
  endfunction

endpackage

// File: rtl/glb_pe_loop_ctrl.sv
// Load-weights / stream-ifmap / drain-psum sequencer for the PE array, repeated per pass.
// Optional GLB_PE_LOOP_WT_REUSE_EN keeps weights resident after pass 0 (skips LOAD_W).
module glb_pe_loop_ctrl
  import glb_pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_ROW    = DEF_NUM_ROW,
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(NUM_ROW+1)-1:0] cfg_k,
  input  logic [CNT_W-1:0]             cfg_w,
  input  logic [CNT_W-1:0]             cfg_passes,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  input  logic                         src_valid,
  output logic                         src_ready,
  output logic [NUM_ROW-1:0]           wt_ld_en,
  output logic [$clog2(NUM_COL)-1:0]   wt_col,
  output logic                         if_en,
  output logic                         psum_valid,
  input  logic                         psum_ready,
  output logic                         psum_shift,
  output logic [CNT_W-1:0]             pass_idx
);

  if (DATA_WIDTH < 1 || NUM_ROW < 2 || NUM_COL < 2 || CNT_W < 2) begin : g_param_chk
    $error("glb_pe_loop_ctrl: unsupported parameter set");
  end

  state_t                      state;
  cfg_t                        cfg_q;
  logic [$clog2(NUM_ROW)-1:0]  row;
  logic [$clog2(NUM_COL)-1:0]  col;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            pass_q;
  logic                        err_q;
  logic                        xfer;
  logic                        col_last;
  logic                        row_last;
  logic                        strm_last;
  logic                        drn_last;
  logic                        pass_last;

  // Handshake outputs decode the state register only, so src_ready never looks at src_valid.
  assign busy       = (state != IDLE);
  assign src_ready  = (state == LOAD_W) || (state == STREAM);
  assign xfer       = src_valid & src_ready;
  assign wt_ld_en   = (state == LOAD_W && xfer) ? (NUM_ROW'(1) << row) : '0;
  assign wt_col     = col;
  assign if_en      = (state == STREAM) && xfer;
  assign psum_valid = (state == DRAIN);
  assign psum_shift = psum_valid & psum_ready;
  assign done       = (state == DONE);
  assign err        = err_q;
  assign pass_idx   = pass_q;

  assign col_last  = (K_W'(col) == cfg_q.k - K_W'(1));
  assign row_last  = (K_W'(row) == cfg_q.k - K_W'(1));
  assign strm_last = (cnt == cfg_q.w - CNT_W'(1));
  // Valid output positions of a k-wide window over w inputs: w-k+1.
  assign drn_last  = (cnt == cfg_q.w - CNT_W'(cfg_q.k));
  assign pass_last = (pass_q == cfg_q.passes - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cfg_q  <= '0;
      row    <= '0;
      col    <= '0;
      cnt    <= '0;
      pass_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cfg_q <= '{k: cfg_k, w: cfg_w, passes: cfg_passes};
            row    <= '0;
            col    <= '0;
            cnt    <= '0;
            pass_q <= '0;
            if (cfg_legal(int'(cfg_k), int'(cfg_w), int'(cfg_passes), NUM_ROW, NUM_COL))
              state <= LOAD_W;
            else
              err_q <= 1'b1;
          end
        end
        LOAD_W: begin
          if (xfer) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                cnt   <= '0;
                state <= STREAM;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (strm_last) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (psum_shift) begin
            if (drn_last) begin
              cnt <= '0;
              row <= '0;
              col <= '0;
              if (pass_last) begin
                state <= DONE;
              end else begin
                pass_q <= pass_q + CNT_W'(1);
`ifdef GLB_PE_LOOP_WT_REUSE_EN
                state  <= STREAM;
`else
                state  <= LOAD_W;
`endif
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          pass_q <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_pe_loop_ctrl.sv
// Randomised and directed bench for glb_pe_loop_ctrl against a transfer-count reference model.
module tb_glb_pe_loop_ctrl;

`ifdef GLB_PE_LOOP_WT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] cfg_k;
  logic [7:0] cfg_w;
  logic [7:0] cfg_passes;
  logic       busy, done, err;
  logic       src_valid, src_ready;
  logic [3:0] wt_ld_en;
  logic [1:0] wt_col;
  logic       if_en, psum_valid, psum_ready, psum_shift;
  logic [7:0] pass_idx;

  int checks = 0;
  int errors = 0;

  glb_pe_loop_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_w(cfg_w),
    .cfg_passes(cfg_passes), .busy(busy), .done(done), .err(err),
    .src_valid(src_valid), .src_ready(src_ready), .wt_ld_en(wt_ld_en), .wt_col(wt_col),
    .if_en(if_en), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_shift(psum_shift), .pass_idx(pass_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_wt_ld_en"}, wt_ld_en, 0);
    chk({tag, "_wt_col"}, wt_col, 0);
    chk({tag, "_if_en"}, if_en, 0);
    chk({tag, "_psum_valid"}, psum_valid, 0);
    chk({tag, "_psum_shift"}, psum_shift, 0);
    chk({tag, "_pass_idx"}, pass_idx, 0);
  endtask

  // vmode: 0 valid always, 1 random, 2 low in job cycles 4-6.  rmode: 0 ready always, 1 toggle, 2 random.
  task automatic run_job(input int k, input int w, input int np, input int vmode, input int rmode,
                         input int exp_done, output int wt_cnt, output int shift_cnt,
                         output int done_cnt);
    int  c, p, s, nload, dlen;
    bit  legal, fin, ld, st, dr;
    wt_cnt = 0; shift_cnt = 0; done_cnt = 0;
    legal = (k >= 1) && (k <= 4) && (w >= k) && (np >= 1);
    @(posedge clk); #1;
    start = 1'b1; cfg_k = 3'(k); cfg_w = 8'(w); cfg_passes = 8'(np);
    src_valid = 1'b0; psum_ready = 1'b0;
    @(negedge clk);
    chk("start_cycle_busy", busy, 0);
    chk("start_cycle_src_ready", src_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    if (!legal) begin
      @(negedge clk);
      chk("illegal_err_pulse", err, 1);
      chk("illegal_busy", busy, 0);
      chk("illegal_src_ready", src_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("illegal_err_clear", err, 0);
      chk("illegal_busy_after", busy, 0);
      chk("illegal_src_ready_after", src_ready, 0);
      return;
    end
    p = 0; s = 0; c = 1; fin = 1'b0;
    dlen = w - k + 1;
    while (!fin && c < 3000) begin
      case (vmode)
        0: src_valid = 1'b1;
        1: src_valid = 1'($urandom_range(0, 1));
        default: src_valid = !(c >= 4 && c <= 6);
      endcase
      case (rmode)
        0: psum_ready = 1'b1;
        1: psum_ready = c[0];
        default: psum_ready = 1'($urandom_range(0, 1));
      endcase
      start = ($urandom_range(0, 3) == 0);
      cfg_k = 3'($urandom_range(0, 7));
      cfg_w = 8'($urandom);
      cfg_passes = 8'($urandom);
      @(negedge clk);
      if (wt_ld_en != 0) wt_cnt++;
      if (psum_shift) shift_cnt++;
      if (done) done_cnt++;
      nload = (REUSE && p > 0) ? 0 : k * k;
      if (p == np) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_src_ready", src_ready, 0);
        chk("done_psum_valid", psum_valid, 0);
        chk("done_pass_idx", pass_idx, np - 1);
        if (exp_done >= 0) chk("done_cycle", c, exp_done);
        fin = 1'b1;
      end else begin
        ld = (s < nload);
        st = !ld && (s < nload + w);
        dr = !ld && !st;
        chk("busy", busy, 1);
        chk("done_early", done, 0);
        chk("err", err, 0);
        chk("pass_idx", pass_idx, p);
        chk("src_ready", src_ready, ld || st);
        chk("wt_ld_en", wt_ld_en, (ld && src_valid) ? (32'd1 << (s / k)) : 0);
        if (ld) chk("wt_col", wt_col, s % k);
        chk("if_en", if_en, st && src_valid);
        chk("psum_valid", psum_valid, dr);
        chk("psum_shift", psum_shift, dr && psum_ready);
        if (dr ? psum_ready : src_valid) s++;
        if (s == nload + w + dlen) begin
          p++;
          s = 0;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
    end
    if (!fin) chk("job_timeout", 0, 1);
    src_valid = 1'b0; psum_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_busy", busy, 0);
    chk("idle_after_done", done, 0);
  endtask

  initial begin
    int wt, sh, dn, k, w, np, exp;
    rst_n = 1'b0; start = 1'b0; cfg_k = '0; cfg_w = '0; cfg_passes = '0;
    src_valid = 1'b0; psum_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Stall-free single pass with the directed timing.
    run_job(3, 5, 1, 0, 0, 18, wt, sh, dn);
    chk("s1_wt_xfers", wt, 9);
    chk("s1_psum_shifts", sh, 3);
    chk("s1_done_count", dn, 1);

    // Source stall in cycles 4-6 stretches the load by three cycles.
    run_job(3, 5, 1, 2, 0, 21, wt, sh, dn);
    chk("s2_wt_xfers", wt, 9);

    // Three passes with toggling downstream ready.
    run_job(2, 4, 3, 0, 1, -1, wt, sh, dn);
    chk("s3_psum_shifts", sh, 9);
    chk("s3_done_count", dn, 1);
    chk("s3_wt_xfers", wt, REUSE ? 4 : 12);

    // Illegal configurations.
    run_job(0, 5, 1, 0, 0, -1, wt, sh, dn);
    run_job(5, 5, 1, 0, 0, -1, wt, sh, dn);
    run_job(3, 2, 1, 0, 0, -1, wt, sh, dn);
    run_job(2, 4, 0, 0, 0, -1, wt, sh, dn);

    // Reset mid-job aborts with everything cleared immediately.
    @(posedge clk); #1;
    start = 1'b1; cfg_k = 3'd3; cfg_w = 8'd5; cfg_passes = 8'd1;
    src_valid = 1'b1; psum_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("abort_pre_if_en", if_en, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("abort_hold");
    src_valid = 1'b0; psum_ready = 1'b0;
    rst_n = 1'b1;
    run_job(3, 5, 1, 0, 0, 18, wt, sh, dn);
    chk("post_abort_wt_xfers", wt, 9);

    // Two passes, stall-free: weight reuse changes both the load count and the length.
    run_job(3, 5, 2, 0, 0, REUSE ? 26 : 35, wt, sh, dn);
    chk("p2_wt_xfers", wt, REUSE ? 9 : 18);
    chk("p2_psum_shifts", sh, 6);

    // Random legal jobs with random stalls on both sides.
    for (int i = 0; i < 8; i++) begin
      k  = $urandom_range(1, 4);
      w  = $urandom_range(k, 9);
      np = $urandom_range(1, 3);
      run_job(k, w, np, 1, 2, -1, wt, sh, dn);
      chk("rand_psum_shifts", sh, np * (w - k + 1));
      chk("rand_done_count", dn, 1);
      chk("rand_wt_xfers", wt, REUSE ? k * k : np * k * k);
    end

    // Random stall-free jobs against the closed-form length.
    for (int i = 0; i < 4; i++) begin
      k  = $urandom_range(1, 4);
      w  = $urandom_range(k, 9);
      np = $urandom_range(1, 3);
      exp = REUSE ? (k * k + np * (2 * w - k + 1) + 1) : (np * (k * k + 2 * w - k + 1) + 1);
      run_job(k, w, np, 0, 0, exp, wt, sh, dn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
